uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between N byte requesters, using round-robin arbitration.
- Sits between requester logic (switch capture, status reporters, etc.) and the transmitter's transmit/data inputs.
- Sequences one frame at a time: latches the winner's byte, drives a held start strobe, then times the frame with an internal counter. The transmitter has no busy output.

Parameters:
- N, 4, number of requesters (1..8)
- FRAME_CYCLES, 105000, clk cycles reserved per transmitted frame, start strobe to next grant (10 bits at 9600 baud from 100 MHz, plus margin)
- START_HOLD, 4, cycles tx_start is held high per frame; legal range 1 <= START_HOLD < FRAME_CYCLES

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  N  per-requester byte request; held until its req_ready
- req_data  input  8*N  byte for requester i on bits [8i+7:8i]
- req_ready  output  N  one-cycle acknowledge to the granted requester; byte has been latched
- tx_start  output  1  to transmitter transmit input
- tx_data  output  8  to transmitter data input; stable for the whole frame
- busy  output  1  high while a frame (or tag+data pair) is in progress
- grant_id  output  3  index of current/last granted requester

Behaviour:
- Reset: all outputs 0 at the next edge; state IDLE; frame counter 0; round-robin pointer = N-1, so requester 0 has highest priority first.
- Reset asserted mid-frame: same as above; tx_start drops at the next edge; no req_ready is issued.
- States: IDLE, SEND (plus TAG with the optional feature).
- IDLE, any req_valid bit high: winner = first set bit searching ptr+1, ptr+2, … with wrap-around modulo N.
- IDLE grant, at the next edge:
  - state <= SEND; req_ready[winner] <= 1 for exactly one cycle.
  - tx_data <= winner's byte; grant_id <= winner; ptr <= winner.
  - tx_start <= 1; busy <= 1; counter <= 0.
- Latency: request seen in cycle k gives req_ready, tx_start and busy high in cycle k+1.
- SEND:
  - counter increments every cycle.
  - tx_start is high while counter < START_HOLD, so it is high for exactly START_HOLD cycles.
  - When counter == FRAME_CYCLES-1: state <= IDLE, busy <= 0.
  - busy is therefore high for exactly FRAME_CYCLES cycles.
- The IDLE cycle is mandatory: the earliest next tx_start rises FRAME_CYCLES+1 cycles after the previous one.
- req_valid changes during SEND are ignored; arbitration happens only in IDLE.
- A request withdrawn before grant is never acknowledged; no error.
- tx_data and grant_id hold their values in IDLE until the next grant.
- Simultaneous requests: served in strict rotation; no requester waits more than N-1 grants.
- N=1: the arbiter degenerates to a pacer; grant_id is always 0.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- Defined:
  - On grant, go to TAG instead of SEND, with tx_data = 8'h80 | winner.
  - TAG runs a full frame (START_HOLD strobe, FRAME_CYCLES length).
  - At its end go directly to SEND with tx_data = latched byte; counter resets and tx_start is re-asserted for START_HOLD cycles.
  - req_ready still pulses at grant.
  - busy stays high for 2*FRAME_CYCLES cycles continuously.
  - Reset in TAG aborts both frames.
- Undefined: the TAG state and its logic do not exist; behaviour is as above.

Test Plan (FRAME_CYCLES=20, START_HOLD=2, N=4):
- Single request: req_valid=4'b0100, req_data[23:16]=8'hA5 → req_ready=4'b0100 for one cycle; tx_data=A5; tx_start high 2 cycles; busy high 20 cycles; grant_id=2.
- All four requesting continuously with bytes 11/22/33/44 → grant order 0,1,2,3,0; tx_start rising edges spaced exactly 21 cycles; each req_ready pulses once per grant.
- Request from 1 while 0's frame is in progress → 1 is not acknowledged until the IDLE cycle after busy falls; its tx_start rises 21 cycles after 0's.
- Reset asserted at counter=7 of a frame → next cycle tx_start=0, busy=0, req_ready=0; the first request after reset from {1,3} grants 1.
- Requester withdraws req_valid before IDLE → no req_ready, tx_start stays 0, ptr unchanged.
- UART_ARB_TAG_EN, request from 3 with 8'h5C → tx_data 8'h83 for 20 cycles then 8'h5C for 20 cycles; two 2-cycle tx_start pulses 20 cycles apart; busy high 40 cycles.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side signal bundle for uart_tx_arbiter.
// The master modport is the requester side; the arbiter uses slave.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           busy;
    logic [2:0]     grant_id;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_start, tx_data, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_start, tx_data, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N byte requesters; frames are timed internally.
// Define UART_ARB_TAG_EN to precede every byte with a tag frame carrying 8'h80 | requester index.
module uart_tx_arbiter #(
    parameter int N            = 4,
    parameter int FRAME_CYCLES = 105000,
    parameter int START_HOLD   = 4
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned   N_U      = N;
    localparam int            CW       = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [2:0]    PTR_RST  = 3'(N - 1);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_TAG} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEND} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    grant_id_q, grant_id_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [N-1:0]  req_ready_q, req_ready_d;
    logic          tx_start_q, tx_start_d;
    logic          busy_q, busy_d;
`ifdef UART_ARB_TAG_EN
    logic [7:0]    byte_q, byte_d;
`endif

    logic [7:0]    valid_pad;
    int unsigned   cand;
    logic          win_found;
    logic [2:0]    win_id;
    logic [7:0]    win_byte;
    logic          frame_last;
    logic          start_next;

    // Search ptr+1, ptr+2, ... modulo N; the first set request wins.
    always_comb begin
        valid_pad        = '0;
        valid_pad[N-1:0] = bus.req_valid;
        cand             = 0;
        win_found        = 1'b0;
        win_id           = '0;
        for (int unsigned i = 1; i <= N_U; i++) begin
            cand = (32'(ptr_q) + i) % N_U;
            if (!win_found && valid_pad[cand[2:0]]) begin
                win_found = 1'b1;
                win_id    = cand[2:0];
            end
        end
    end

    always_comb begin
        win_byte = '0;
        for (int unsigned i = 0; i < N_U; i++) begin
            if (3'(i) == win_id) begin
                win_byte = bus.req_data[8*i +: 8];
            end
        end
    end

    assign frame_last = (cnt_q == CNT_LAST);
    assign start_next = (int'(cnt_q) + 1) < START_HOLD;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        tx_data_d   = tx_data_q;
        req_ready_d = '0;
        tx_start_d  = 1'b0;
        busy_d      = busy_q;
`ifdef UART_ARB_TAG_EN
        byte_d      = byte_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    for (int unsigned i = 0; i < N_U; i++) begin
                        req_ready_d[i] = (3'(i) == win_id);
                    end
                    grant_id_d = win_id;
                    ptr_d      = win_id;
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
`ifdef UART_ARB_TAG_EN
                    state_d    = S_TAG;
                    tx_data_d  = 8'h80 | {5'b0, win_id};
                    byte_d     = win_byte;
`else
                    state_d    = S_SEND;
                    tx_data_d  = win_byte;
`endif
                end
            end
            S_SEND: begin
                cnt_d      = cnt_q + 1'b1;
                tx_start_d = start_next;
                if (frame_last) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
`ifdef UART_ARB_TAG_EN
            // Tag frame rolls straight into the data frame; busy never drops in between.
            S_TAG: begin
                cnt_d      = cnt_q + 1'b1;
                tx_start_d = start_next;
                if (frame_last) begin
                    state_d    = S_SEND;
                    cnt_d      = '0;
                    tx_start_d = 1'b1;
                    tx_data_d  = byte_q;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= PTR_RST;
            grant_id_q  <= '0;
            tx_data_q   <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_ARB_TAG_EN
            byte_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            tx_data_q   <= tx_data_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
`ifdef UART_ARB_TAG_EN
            byte_q      <= byte_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_id_q;

endmodule
